// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, flag indices and FSM states shared by seq_alu and muldiv_iter
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_MULT = 4'b0010;
  localparam logic [3:0] ALU_MULTU = 4'b0011;
  localparam logic [3:0] ALU_DIV  = 4'b0100;
  localparam logic [3:0] ALU_DIVU = 4'b0101;
  localparam logic [3:0] ALU_AND  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b1000;
  localparam logic [3:0] ALU_XOR  = 4'b1001;
  localparam logic [3:0] ALU_SLT  = 4'b1010;
  localparam logic [3:0] ALU_SLTU = 4'b1011;
  localparam logic [3:0] ALU_SLL  = 4'b1100;
  localparam logic [3:0] ALU_SRL  = 4'b1101;
  localparam logic [3:0] ALU_SRA  = 4'b1110;
  localparam logic [3:0] ALU_INV  = 4'b1111;

  localparam int ZON_Z = 2;
  localparam int ZON_O = 1;
  localparam int ZON_N = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - radix-2 shift-add multiplier / restoring divider on unsigned magnitudes
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         is_div,
  input  logic         is_signed,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         run,
  output logic         last,
  output logic [W-1:0] hi_fix,
  output logic [W-1:0] lo_fix,
  output logic [2:0]   zon_fix
);

  localparam int CNT_W = $clog2(W) + 1;

  // acc_hi: partial product / remainder; acc_lo: multiplier / dividend turning into quotient
  logic [W-1:0]     acc_hi, acc_lo, opnd;
  logic [CNT_W-1:0] cnt;
  logic             div_q, qneg_q, rneg_q, ovf_q;

  logic             a_neg, b_neg;
  logic [W-1:0]     mag_a, mag_b;
  logic [W:0]       add_sum, shifted, diff;
  logic             ge;
  logic [2*W-1:0]   prod_fix;

  always_comb begin
    a_neg    = is_signed && a[W-1];
    b_neg    = is_signed && b[W-1];
    mag_a    = a_neg ? -a : a;
    mag_b    = b_neg ? -b : b;
    add_sum  = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {W{1'b0}})};
    shifted  = {acc_hi, acc_lo[W-1]};
    diff     = shifted - {1'b0, opnd};
    ge       = ~diff[W];
    last     = (cnt == CNT_W'(W - 1));
    hi_fix   = '0;
    lo_fix   = '0;
    zon_fix  = '0;
    prod_fix = '0;
    if (div_q) begin
      lo_fix         = qneg_q ? -acc_lo : acc_lo;
      hi_fix         = rneg_q ? -acc_hi : acc_hi;
      zon_fix[ZON_Z] = (lo_fix == '0);
      zon_fix[ZON_O] = ovf_q;
      zon_fix[ZON_N] = lo_fix[W-1];
    end else begin
      prod_fix         = qneg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
      {hi_fix, lo_fix} = prod_fix;
      zon_fix[ZON_Z]   = (prod_fix == '0);
      zon_fix[ZON_N]   = prod_fix[2*W-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      cnt    <= '0;
      div_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (start) begin
      // multiply is commutative, so both ops share the same operand placement
      acc_hi <= '0;
      acc_lo <= mag_a;
      opnd   <= mag_b;
      cnt    <= '0;
      div_q  <= is_div;
      qneg_q <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      ovf_q  <= is_div && is_signed && (a == {1'b1, {(W-1){1'b0}}}) && (b == {W{1'b1}});
    end else if (run) begin
      cnt <= cnt + 1'b1;
      if (div_q) begin
        acc_hi <= ge ? diff[W-1:0] : shifted[W-1:0];
        acc_lo <= {acc_lo[W-2:0], ge};
      end else begin
        acc_hi <= add_sum[W:1];
        acc_lo <= {add_sum[0], acc_lo[W-1:1]};
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered MIPS ALU with iterative mult/div and architectural HI/LO
module seq_alu
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   alu_ctr,
  input  logic         ovf_en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  output logic [W-1:0] result,
  output logic [2:0]   zon,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy
);

  localparam int SH_W = $clog2(W);

  state_t          state;
  logic            accept, is_md, is_div, is_signed, div_zero, start, md_last;
  logic [W-1:0]    md_hi, md_lo;
  logic [2:0]      md_zon;
  logic [W-1:0]    res_c;
  logic [2:0]      zon_c;
  logic [SH_W-1:0] shamt;

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN) || (state == FIX);
  assign accept    = in_valid && in_ready;
  assign is_div    = (alu_ctr == ALU_DIV) || (alu_ctr == ALU_DIVU);
  assign is_md     = is_div || (alu_ctr == ALU_MULT) || (alu_ctr == ALU_MULTU);
  assign is_signed = (alu_ctr == ALU_MULT) || (alu_ctr == ALU_DIV);
  assign div_zero  = is_div && (b == '0);
  assign start     = accept && is_md && !div_zero;

  always_comb begin
    res_c = '0;
    zon_c = '0;
    shamt = b[SH_W-1:0];
    case (alu_ctr)
      ALU_ADD: begin
        res_c        = a + b;
        zon_c[ZON_O] = ovf_en && (a[W-1] == b[W-1]) && (res_c[W-1] != a[W-1]);
      end
      ALU_SUB: begin
        res_c        = a - b;
        zon_c[ZON_O] = ovf_en && (a[W-1] != b[W-1]) && (res_c[W-1] != a[W-1]);
      end
      ALU_AND:  res_c = a & b;
      ALU_NOR:  res_c = ~(a | b);
      ALU_OR:   res_c = a | b;
      ALU_XOR:  res_c = a ^ b;
      ALU_SLT:  res_c = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: res_c = {{(W-1){1'b0}}, (a < b)};
      ALU_SLL:  res_c = a << shamt;
      ALU_SRL:  res_c = a >> shamt;
      ALU_SRA:  res_c = $signed(a) >>> shamt;
      default:  res_c = '0;
    endcase
    // slt results are 0/1 with W >= 8, so the sign bit is naturally clear
    zon_c[ZON_Z] = (res_c == '0);
    zon_c[ZON_N] = res_c[W-1];
  end

  muldiv_iter #(.W(W)) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_div    (is_div),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .run       (state == RUN),
    .last      (md_last),
    .hi_fix    (md_hi),
    .lo_fix    (md_lo),
    .zon_fix   (md_zon)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zon       <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
          end else if (accept && div_zero) begin
            hi        <= a;
            lo        <= '1;
            result    <= '1;
            zon       <= 3'b010;
            out_valid <= 1'b1;
          end else if (accept) begin
            result    <= res_c;
            zon       <= zon_c;
            out_valid <= 1'b1;
          end
        end
        RUN: begin
          if (md_last) state <= FIX;
        end
        FIX: begin
          hi        <= md_hi;
          lo        <= md_lo;
          result    <= md_lo;
          zon       <= md_zon;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized scoreboard bench for seq_alu against an arithmetic reference model
module tb_seq_alu;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         ovf_en = 1'b0;
  logic [3:0]   alu_ctr = 4'd0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] result, hi, lo;
  logic [2:0]   zon;

  seq_alu #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctr(alu_ctr), .ovf_en(ovf_en), .a(a), .b(b), .out_valid(out_valid),
    .result(result), .zon(zon), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  zon;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        me;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer arithmetic; cyc holds the cycle offset at which out_valid is seen
  function automatic exp_t model(input logic [3:0] op, input logic ov, input logic [31:0] x,
                                 input logic [31:0] y, input logic [31:0] chi, input logic [31:0] clo);
    exp_t e;
    longint s;
    logic signed [63:0] sp;
    logic [63:0] up;
    int sx, sy;
    e.res = '0; e.zon = 3'b000; e.hi = chi; e.lo = clo; e.cyc = 1;
    sx = x; sy = y;
    case (op)
      4'd0, 4'd1: begin
        s = (op == 4'd0) ? longint'($signed(x)) + longint'($signed(y))
                         : longint'($signed(x)) - longint'($signed(y));
        e.res = s[31:0];
        e.zon = {e.res == 0, ov && (s > SMAX || s < SMIN), e.res[31]};
      end
      4'd2, 4'd3: begin
        if (op == 4'd2) begin
          sp = longint'($signed(x)) * longint'($signed(y));
          up = sp;
        end else begin
          up = {32'b0, x} * {32'b0, y};
        end
        {e.hi, e.lo} = up;
        e.zon = {up == 0, 1'b0, up[63]};
        e.cyc = W + 2;
      end
      4'd4, 4'd5: begin
        if (y == 0) begin
          e.hi = x; e.lo = '1; e.zon = 3'b010;
        end else if (op == 4'd4 && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          e.hi = 0; e.lo = 32'h8000_0000; e.zon = 3'b011; e.cyc = W + 2;
        end else begin
          if (op == 4'd4) begin
            e.lo = sx / sy; e.hi = sx % sy;
          end else begin
            e.lo = x / y; e.hi = x % y;
          end
          e.zon = {e.lo == 0, 1'b0, e.lo[31]};
          e.cyc = W + 2;
        end
      end
      4'd6:  e.res = x & y;
      4'd7:  e.res = ~(x | y);
      4'd8:  e.res = x | y;
      4'd9:  e.res = x ^ y;
      4'd10: e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd11: e.res = (x < y) ? 32'd1 : 32'd0;
      4'd12: e.res = x << y[4:0];
      4'd13: e.res = x >> y[4:0];
      4'd14: e.res = $signed(x) >>> y[4:0];
      default: e.res = '0;
    endcase
    if (op inside {[4'd2:4'd5]}) e.res = e.lo;
    else if (op >= 4'd6) e.zon = {e.res == 0, 1'b0, e.res[31]};
    return e;
  endfunction

  task automatic issue(input logic [3:0] op, input logic ov, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_before_issue", in_ready, 1);
    alu_ctr = op; ovf_en = ov; a = x; b = y; in_valid = 1'b1;
    e = model(op, ov, x, y, m_hi, m_lo);
    e.cyc = cyc + e.cyc;
    m_hi = e.hi;
    m_lo = e.lo;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: result %h with empty scoreboard", result);
      end else begin
        me = sb.pop_front();
        chk("result", result, me.res);
        chk("zon", zon, me.zon);
        chk("hi", hi, me.hi);
        chk("lo", lo, me.lo);
        chk("latency_cycle", cyc, me.cyc);
      end
    end
  end

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_zon", zon, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'd0, 1'b1, 32'h7FFF_FFFF, 32'h1);
    issue(4'd0, 1'b0, 32'h7FFF_FFFF, 32'h1);
    issue(4'd2, 1'b0, 32'hFFFF_FFFD, 32'h7);
    issue(4'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(4'd4, 1'b0, 32'hFFFF_FFF9, 32'h2);
    issue(4'd5, 1'b0, 32'h7, 32'h0);
    issue(4'd4, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(4'd14, 1'b0, 32'h8000_0000, 32'h4);
    issue(4'd10, 1'b0, 32'hFFFF_FFFF, 32'h1);
    issue(4'd11, 1'b0, 32'hFFFF_FFFF, 32'h1);
    issue(4'd15, 1'b0, 32'h1234_5678, 32'h9);
    issue(4'd12, 1'b0, 32'h1, 32'h13);
    issue(4'd1, 1'b1, 32'h8000_0000, 32'h1);
    drain();

    for (int i = 0; i < 200; i++) begin
      issue(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), pick(), pick());
    end
    drain();

    issue(4'd4, 1'b0, $urandom, 32'h3);
    repeat (9) @(negedge clk);
    chk("busy_mid_div", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", result, 0);
    chk("midrst_zon", zon, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_busy", busy, 0);
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);
    issue(4'd0, 1'b0, 32'd2, 32'd3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational MIPS ALU.
- Single-cycle ops (add/sub/logic/compare/shift) complete in 1 cycle.
- mult/multu/div/divu run on an iterative radix-2 datapath lasting W+1 cycles.
- Owns architectural HI/LO registers and sits between the ID/EX control decode and the EX/MEM stage, with a valid/ready handshake so the pipeline stalls on multi-cycle ops.

Parameters:
- W, 32, datapath width; power of two, at least 8.
- SH_W, $clog2(W), shift-amount width (derived; do not override).
- CNT_W, $clog2(W)+1, iteration counter width (derived).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high when the block can accept; equals (state==IDLE), combinational.
- alu_ctr  in  4  op code: 0000 add, 0001 sub, 0010 mult, 0011 multu, 0100 div, 0101 divu, 0110 and, 0111 nor, 1000 or, 1001 xor, 1010 slt, 1011 sltu, 1100 sll, 1101 srl, 1110 sra, 1111 invalid.
- ovf_en  in  1  enables the add/sub overflow flag (add/sub/addi = 1; addu/subu = 0).
- a  in  W  operand A; the shifted value for shifts; the dividend.
- b  in  W  operand B, already sign- or zero-extended upstream; shift amount is b[SH_W-1:0]; the divisor.
- out_valid  out  1  one-cycle pulse; result, zon, hi and lo are valid while high.
- result  out  W  registered result; equals lo for mult/div ops.
- zon  out  3  registered flags: [2] zero, [1] overflow, [0] negative.
- hi  out  W  HI register.
- lo  out  W  LO register.
- busy  out  1  high while in RUN or FIX.

Behaviour:
- Reset values (async, rst_n=0): state=IDLE, out_valid=0, result=0, zon=000, hi=0, lo=0, busy=0, counter=0. Reset mid-operation discards the operation; HI/LO return to 0.
- Accept condition: in_valid && in_ready, sampled at a rising edge. Inputs are don't-care otherwise.
- Single-cycle ops: result and zon are registered at the accept edge. out_valid is high for the following cycle. Back-to-back accepts are allowed every cycle.
- add/sub: result is modulo 2^W. zon[1] = ovf_en && signed overflow. zon[0] = result[W-1]. zon[2] = (result==0).
- Logic ops: zon[0] = result[W-1], zon[2] = (result==0), zon[1] = 0.
- slt/sltu: result is 0 or 1; zon[0] = 0.
- sll/srl: logical shift of a by b[SH_W-1:0]. sra: arithmetic shift of a by the same amount.
- Invalid code (1111): result=0, zon=100, out_valid still pulses.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on accepting a mult/multu/div/divu with a nonzero divisor.
  - RUN -> FIX after W iterations (counter reaches W-1).
  - FIX -> IDLE unconditionally.
- Edge timing for multi-cycle ops: accept at edge E0. Operands are latched as magnitudes (signed ops) with result sign = a[W-1]^b[W-1] and remainder sign = a[W-1]. RUN covers edges E1..EW. FIX at E(W+1) applies sign correction, writes hi, lo, result and zon, and raises out_valid.
- Latency is W+1 cycles. in_ready is low for W+1 cycles.
- Multiply: shift-add, one bit per cycle. {hi,lo} is the 2W-bit product. zon[2] = ({hi,lo}==0), zon[0] = hi[W-1], zon[1] = 0.
- Divide: restoring, one quotient bit per cycle. lo = quotient, truncated toward zero. hi = remainder, carrying the sign of the dividend. zon[2] = (lo==0), zon[0] = lo[W-1].
- Divide by zero: stays in IDLE, completes in 1 cycle. lo = all ones, hi = a, zon[1] = 1.
- Signed div of -2^(W-1) by -1: lo = 0x80..0, hi = 0, zon[1] = 1.
- HI/LO are written only at FIX or on the divide-by-zero completion; all other ops leave them unchanged.

Decomposition:
- Package alu_pkg holds:
  - alu_ctr localparams (ALU_ADD..ALU_SRA, ALU_INV);
  - zon bit indices (ZON_Z=2, ZON_O=1, ZON_N=0);
  - the FSM state enum {IDLE, RUN, FIX}.
- Sub-module muldiv_iter (parameter W) holds the iterative multiply/divide datapath: accumulator, counter, one-bit step and sign fix-up.
- seq_alu keeps the single-cycle datapath, FSM, handshake and HI/LO registers.

Test Plan:
1. W=32, add a=0x7FFFFFFF, b=1, ovf_en=1 -> next cycle result=0x80000000, zon=011. Same with ovf_en=0 -> zon=001.
2. mult a=0xFFFFFFFD (-3), b=7 -> in_ready low 33 cycles; out_valid at cycle 33 with hi=0xFFFFFFFF, lo=0xFFFFFFEB, zon=001. multu 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
3. div a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> out_valid next cycle, lo=0xFFFFFFFF, hi=7, zon=010. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0, zon[1]=1.
4. Back-to-back: sra a=0x80000000, b=4 -> 0xF8000000 (zon=001); then slt -1,1 -> 1; then sltu -1,1 -> 0 (zon=100), on consecutive cycles. HI/LO are unchanged.
5. Assert rst_n low at cycle 10 of a div -> outputs 0 immediately. After release, in_ready=1 and a following add 2+3 gives 5.
6. W=16 build: mult 0x8000*0x8000 -> hi=0x4000, lo=0x0000 after 17 cycles. sll 1 by b=0x0013 uses amount 3 -> 0x0008.
